// File: rtl/ball_ctrl_pkg.sv
// Shared playfield geometry for the pong datapath (display size, border, paddle, ball).
// Coordinates are compared in 11 bits so border arithmetic near zero cannot wrap.
package ball_ctrl_pkg;

    localparam int H_DISP     = 640;
    localparam int V_DISP     = 480;
    localparam int SLDE_W     = 10;
    localparam int body_l     = 80;
    localparam int body_w     = 10;
    localparam int BALL_W_DEF = 10;
    localparam int CMP_W      = 11;

    function automatic logic [CMP_W-1:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick is high for one vga_clk cycle every TICK_DIV cycles.
// Shared with the paddle position stage.
module tick_gen #(
    parameter int TICK_DIV = 250000
) (
    input  logic vga_clk,
    input  logic sys_rst,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/ball_ctrl.sv
// Ball motion engine: wall bounces, paddle collision and miss detection on a divided tick.
// Optional build macro SPEEDUP_EN: each paddle hit raises the step by one, up to MAX_STEP.
//
// state | meaning
// IDLE  | ball parked at serve point, waiting for serve
// MOVE  | ball advances one step per tick
// MISS  | ball frozen at left border for MISS_TICKS ticks
module ball_ctrl
    import ball_ctrl_pkg::*;
#(
    parameter int BALL_W     = BALL_W_DEF,
    parameter int TICK_DIV   = 250000,
    parameter int STEP       = 2,
    parameter int MAX_STEP   = 6,
    parameter int X_INIT     = 315,
    parameter int Y_INIT     = 235,
    parameter int MISS_TICKS = 60
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       serve,
    input  logic [9:0] body_x,
    input  logic [9:0] body_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       hit,
    output logic       miss,
    output logic       active
);

    localparam int Y_MAX  = V_DISP - SLDE_W - BALL_W;
    localparam int X_MAX  = H_DISP - SLDE_W - BALL_W;
    localparam int STEP_W = $clog2(MAX_STEP + 1);
    localparam int MC_W   = (MISS_TICKS > 1) ? $clog2(MISS_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_MISS = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [9:0]        ball_x_n, ball_y_n;
    logic              dx_right, dx_right_n;
    logic              dy_up, dy_up_n;
    logic [STEP_W-1:0] step, step_n;
    logic [MC_W-1:0]   miss_cnt, miss_cnt_n;
    logic              hit_n, miss_n, active_n;
    logic              tick;

    logic [CMP_W-1:0]  x_w, y_w, s_w, px_w, py_w;
    logic              paddle_contact;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .vga_clk (vga_clk),
        .sys_rst (sys_rst),
        .tick    (tick)
    );

    assign x_w  = ext11(ball_x);
    assign y_w  = ext11(ball_y);
    assign px_w = ext11(body_x);
    assign py_w = ext11(body_y);
    assign s_w  = CMP_W'(step);

    // Ball must still be right of the paddle face and overlap it vertically.
    assign paddle_contact = !dx_right
                          && (x_w <= px_w + CMP_W'(body_w) + s_w)
                          && (x_w > px_w)
                          && (y_w + CMP_W'(BALL_W) > py_w)
                          && (y_w < py_w + CMP_W'(body_l));

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            ball_x   <= 10'(X_INIT);
            ball_y   <= 10'(Y_INIT);
            dx_right <= 1'b0;
            dy_up    <= 1'b0;
            step     <= STEP_W'(STEP);
            miss_cnt <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= state_n;
            ball_x   <= ball_x_n;
            ball_y   <= ball_y_n;
            dx_right <= dx_right_n;
            dy_up    <= dy_up_n;
            step     <= step_n;
            miss_cnt <= miss_cnt_n;
            hit      <= hit_n;
            miss     <= miss_n;
            active   <= active_n;
        end
    end

    always_comb begin
        state_n    = state;
        ball_x_n   = ball_x;
        ball_y_n   = ball_y;
        dx_right_n = dx_right;
        dy_up_n    = dy_up;
        step_n     = step;
        miss_cnt_n = miss_cnt;
        hit_n      = 1'b0;
        miss_n     = 1'b0;

        unique case (state)
            S_IDLE: begin
                ball_x_n = 10'(X_INIT);
                ball_y_n = 10'(Y_INIT);
                if (serve) begin
                    state_n    = S_MOVE;
                    dx_right_n = 1'b0;
                    dy_up_n    = 1'b0;
                    step_n     = STEP_W'(STEP);
                end
            end

            S_MOVE: begin
                if (tick) begin
                    if (!dy_up) begin
                        if (y_w + s_w >= CMP_W'(Y_MAX)) begin
                            ball_y_n = 10'(Y_MAX);
                            dy_up_n  = 1'b1;
                        end else begin
                            ball_y_n = 10'(y_w + s_w);
                        end
                    end else begin
                        if (y_w <= CMP_W'(SLDE_W) + s_w) begin
                            ball_y_n = 10'(SLDE_W);
                            dy_up_n  = 1'b0;
                        end else begin
                            ball_y_n = 10'(y_w - s_w);
                        end
                    end

                    if (dx_right) begin
                        if (x_w + s_w >= CMP_W'(X_MAX)) begin
                            ball_x_n   = 10'(X_MAX);
                            dx_right_n = 1'b0;
                        end else begin
                            ball_x_n = 10'(x_w + s_w);
                        end
                    end else if (paddle_contact) begin
                        ball_x_n   = 10'(px_w + CMP_W'(body_w));
                        dx_right_n = 1'b1;
                        hit_n      = 1'b1;
`ifdef SPEEDUP_EN
                        if (step < STEP_W'(MAX_STEP)) begin
                            step_n = step + 1'b1;
                        end
`endif
                    end else if (x_w <= CMP_W'(SLDE_W) + s_w) begin
                        ball_x_n   = 10'(SLDE_W);
                        miss_n     = 1'b1;
                        state_n    = S_MISS;
                        miss_cnt_n = MC_W'(MISS_TICKS - 1);
                    end else begin
                        ball_x_n = 10'(x_w - s_w);
                    end
                end
            end

            S_MISS: begin
                if (tick) begin
                    if (miss_cnt == '0) begin
                        state_n  = S_IDLE;
                        ball_x_n = 10'(X_INIT);
                        ball_y_n = 10'(Y_INIT);
                    end else begin
                        miss_cnt_n = miss_cnt - 1'b1;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        active_n = (state_n == S_MOVE);
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl with TICK_DIV=4; expected positions are hand-traced trajectories.
module tb_ball_ctrl;

    logic       vga_clk = 1'b0;
    logic       sys_rst;
    logic       serve;
    logic [9:0] body_x;
    logic [9:0] body_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       hit;
    logic       miss;
    logic       active;

    int total = 0;
    int bad   = 0;
    int hit_cyc  = 0;
    int miss_cyc = 0;

    always #5 vga_clk = ~vga_clk;

    ball_ctrl #(.TICK_DIV(4)) dut (
        .vga_clk (vga_clk),
        .sys_rst (sys_rst),
        .serve   (serve),
        .body_x  (body_x),
        .body_y  (body_y),
        .ball_x  (ball_x),
        .ball_y  (ball_y),
        .hit     (hit),
        .miss    (miss),
        .active  (active)
    );

    // cycles spent high, so a stretched pulse shows up as an extra count
    always @(negedge vga_clk) begin
        if (hit === 1'b1)  hit_cyc  <= hit_cyc + 1;
        if (miss === 1'b1) miss_cyc <= miss_cyc + 1;
    end

    task automatic cyc();
        @(negedge vga_clk);
        #1;
    endtask

    // advance n movement ticks, each recognised by a position change
    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            logic [9:0] ox, oy;
            int c;
            ox = ball_x;
            oy = ball_y;
            c = 0;
            do begin
                cyc();
                c++;
            end while (ball_x === ox && ball_y === oy && c < 12);
            if (ball_x === ox && ball_y === oy) begin
                total++;
                bad++;
                $display("FAIL adv_timeout tick=%0d pos=(%0d,%0d) unchanged", i, ball_x, ball_y);
                return;
            end
        end
    endtask

    task automatic test_reset();
        int h0, m0;
        sys_rst = 1'b1;
        serve   = 1'b0;
        body_x  = 10'd55;
        body_y  = 10'd0;
        repeat (3) cyc();
        total++;
        if ({ball_x, ball_y, active, hit, miss} !== {10'd315, 10'd235, 3'b000}) begin
            bad++;
            $display("FAIL reset_state got=(%0d,%0d) a=%b h=%b m=%b exp=(315,235) 0 0 0",
                     ball_x, ball_y, active, hit, miss);
        end
        sys_rst = 1'b0;
        h0 = hit_cyc;
        m0 = miss_cyc;
        repeat (100) cyc();
        total++;
        if ({ball_x, ball_y} !== {10'd315, 10'd235}) begin
            bad++;
            $display("FAIL idle_pos got=(%0d,%0d) exp=(315,235)", ball_x, ball_y);
        end
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL idle_active got=%b exp=0", active);
        end
        total++;
        if ((hit_cyc - h0) != 0 || (miss_cyc - m0) != 0) begin
            bad++;
            $display("FAIL idle_pulses got hit=%0d miss=%0d exp 0 0", hit_cyc - h0, miss_cyc - m0);
        end
    endtask

    task automatic test_miss();
        int h0, m0, c;
        body_x = 10'd55;
        body_y = 10'd0;
        h0 = hit_cyc;
        m0 = miss_cyc;
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        total++;
        if (active !== 1'b1) begin
            bad++;
            $display("FAIL serve_active got=%b exp=1", active);
        end
        adv(112);
        total++;
        if ({ball_x, ball_y} !== {10'd91, 10'd459}) begin
            bad++;
            $display("FAIL pre_bottom got=(%0d,%0d) exp=(91,459)", ball_x, ball_y);
        end
        adv(1);
        total++;
        if ({ball_x, ball_y} !== {10'd89, 10'd460}) begin
            bad++;
            $display("FAIL bottom_clamp got=(%0d,%0d) exp=(89,460)", ball_x, ball_y);
        end
        adv(1);
        total++;
        if ({ball_x, ball_y} !== {10'd87, 10'd458}) begin
            bad++;
            $display("FAIL bottom_bounce got=(%0d,%0d) exp=(87,458)", ball_x, ball_y);
        end
        adv(38);
        total++;
        if ({ball_x, ball_y, miss} !== {10'd11, 10'd382, 1'b0}) begin
            bad++;
            $display("FAIL pre_miss got=(%0d,%0d) m=%b exp=(11,382) 0", ball_x, ball_y, miss);
        end
        adv(1);
        total++;
        if ({ball_x, ball_y} !== {10'd10, 10'd380}) begin
            bad++;
            $display("FAIL miss_pos got=(%0d,%0d) exp=(10,380)", ball_x, ball_y);
        end
        total++;
        if ({miss, active} !== 2'b10) begin
            bad++;
            $display("FAIL miss_flags got m=%b a=%b exp m=1 a=0", miss, active);
        end
        total++;
        if ((hit_cyc - h0) != 0) begin
            bad++;
            $display("FAIL miss_no_hit got=%0d exp=0", hit_cyc - h0);
        end
        serve = 1'b1;
        repeat (20) cyc();
        serve = 1'b0;
        repeat (218) cyc();
        total++;
        if ({ball_x, ball_y, active} !== {10'd10, 10'd380, 1'b0}) begin
            bad++;
            $display("FAIL miss_frozen got=(%0d,%0d) a=%b exp=(10,380) 0", ball_x, ball_y, active);
        end
        total++;
        if ((miss_cyc - m0) != 1) begin
            bad++;
            $display("FAIL miss_width got=%0d exp=1", miss_cyc - m0);
        end
        c = 0;
        while (!(ball_x === 10'd315 && ball_y === 10'd235) && c < 6) begin
            cyc();
            c++;
        end
        total++;
        if (c != 2) begin
            bad++;
            $display("FAIL miss_recentre got_cycles=%0d exp=2 pos=(%0d,%0d)", c, ball_x, ball_y);
        end
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_miss_active got=%b exp=0", active);
        end
    endtask

    task automatic test_hit_corner();
        int h0;
        body_x = 10'd120;
        body_y = 10'd380;
        h0 = hit_cyc;
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        adv(92);
        total++;
        if ({ball_x, ball_y} !== {10'd131, 10'd419} || (hit_cyc - h0) != 0) begin
            bad++;
            $display("FAIL pre_hit got=(%0d,%0d) hits=%0d exp=(131,419) 0", ball_x, ball_y, hit_cyc - h0);
        end
        adv(1);
        total++;
        if ({ball_x, ball_y} !== {10'd130, 10'd421}) begin
            bad++;
            $display("FAIL paddle_clamp got=(%0d,%0d) exp=(130,421)", ball_x, ball_y);
        end
        total++;
        if ({hit, active} !== 2'b11) begin
            bad++;
            $display("FAIL hit_pulse got h=%b a=%b exp 1 1", hit, active);
        end
        adv(19);
        total++;
        if ({ball_x, ball_y} !== {10'd168, 10'd459} || (hit_cyc - h0) != 1) begin
            bad++;
            $display("FAIL after_hit got=(%0d,%0d) hitcyc=%0d exp=(168,459) 1", ball_x, ball_y, hit_cyc - h0);
        end
        adv(2);
        total++;
        if ({ball_x, ball_y} !== {10'd172, 10'd458}) begin
            bad++;
            $display("FAIL right_bottom got=(%0d,%0d) exp=(172,458)", ball_x, ball_y);
        end
        adv(223);
        total++;
        if ({ball_x, ball_y} !== {10'd618, 10'd12}) begin
            bad++;
            $display("FAIL pre_corner got=(%0d,%0d) exp=(618,12)", ball_x, ball_y);
        end
        adv(1);
        total++;
        if ({ball_x, ball_y} !== {10'd620, 10'd10}) begin
            bad++;
            $display("FAIL corner got=(%0d,%0d) exp=(620,10)", ball_x, ball_y);
        end
        adv(1);
        total++;
        if ({ball_x, ball_y} !== {10'd618, 10'd12}) begin
            bad++;
            $display("FAIL corner_flip got=(%0d,%0d) exp=(618,12)", ball_x, ball_y);
        end
        adv(243);
        total++;
        if ({ball_x, ball_y} !== {10'd132, 10'd422}) begin
            bad++;
            $display("FAIL pre_hit2 got=(%0d,%0d) exp=(132,422)", ball_x, ball_y);
        end
        adv(1);
        total++;
        if ({ball_x, ball_y} !== {10'd130, 10'd420} || (hit_cyc - h0) != 2) begin
            bad++;
            $display("FAIL hit2 got=(%0d,%0d) hitcyc=%0d exp=(130,420) 2", ball_x, ball_y, hit_cyc - h0);
        end
        adv(1);
        total++;
        if ({ball_x, ball_y} !== {10'd132, 10'd418}) begin
            bad++;
            $display("FAIL hit2_rebound got=(%0d,%0d) exp=(132,418)", ball_x, ball_y);
        end
    endtask

    task automatic test_reset_midflight();
        sys_rst = 1'b1;
        cyc();
        total++;
        if ({ball_x, ball_y, active, hit, miss} !== {10'd315, 10'd235, 3'b000}) begin
            bad++;
            $display("FAIL midflight_reset got=(%0d,%0d) a=%b h=%b m=%b exp=(315,235) 0 0 0",
                     ball_x, ball_y, active, hit, miss);
        end
        sys_rst = 1'b0;
        serve = 1'b1;
        cyc();
        total++;
        if (active !== 1'b1) begin
            bad++;
            $display("FAIL reserve_active got=%b exp=1", active);
        end
        adv(1);
        serve = 1'b0;
        total++;
        if ({ball_x, ball_y} !== {10'd313, 10'd237}) begin
            bad++;
            $display("FAIL reserve_first_step got=(%0d,%0d) exp=(313,237)", ball_x, ball_y);
        end
        sys_rst = 1'b1;
        cyc();
        sys_rst = 1'b0;
    endtask

`ifdef SPEEDUP_EN
    task automatic test_speedup();
        int exp_step [5] = '{3, 4, 5, 6, 6};
        int c;
        int x0;
        body_x = 10'd55;
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        for (int h = 0; h < 5; h++) begin
            c = 0;
            while (hit !== 1'b1 && c < 4000) begin
                body_y = (ball_y >= 10'd20) ? ball_y - 10'd20 : 10'd0;
                cyc();
                c++;
            end
            total++;
            if (hit !== 1'b1) begin
                bad++;
                $display("FAIL speedup_hit_timeout hit_index=%0d", h);
                return;
            end
            x0 = int'(ball_x);
            total++;
            if (x0 != 65) begin
                bad++;
                $display("FAIL speedup_hit_x index=%0d got=%0d exp=65", h, x0);
            end
            adv(1);
            total++;
            if (int'(ball_x) - x0 != exp_step[h]) begin
                bad++;
                $display("FAIL speedup_step index=%0d got=%0d exp=%0d", h, int'(ball_x) - x0, exp_step[h]);
            end
        end
        c = 0;
        while (miss !== 1'b1 && c < 4000) begin
            body_y = (ball_y >= 10'd240) ? 10'd0 : 10'd400;
            cyc();
            c++;
        end
        total++;
        if (miss !== 1'b1) begin
            bad++;
            $display("FAIL speedup_miss_timeout pos=(%0d,%0d)", ball_x, ball_y);
            return;
        end
        c = 0;
        while (!(ball_x === 10'd315 && ball_y === 10'd235) && c < 400) begin
            cyc();
            c++;
        end
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        adv(1);
        total++;
        if ({ball_x, ball_y} !== {10'd313, 10'd237}) begin
            bad++;
            $display("FAIL speedup_serve_step got=(%0d,%0d) exp=(313,237)", ball_x, ball_y);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1;
        serve   = 1'b0;
        body_x  = 10'd0;
        body_y  = 10'd0;
        test_reset();
        test_miss();
        test_hit_corner();
        test_reset_midflight();
`ifdef SPEEDUP_EN
        test_speedup();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
Ball motion engine for the pong playfield, directly downstream of the paddle position stage: consumes the paddle top-left coordinate (body_x, body_y) and produces the ball top-left coordinate for the VGA renderer. Handles wall bounces, paddle collision and miss detection, with a serve/miss state machine. Moves on a divided tick derived from vga_clk.

Parameters:
BALL_W, 10, ball side length in pixels (square ball)
TICK_DIV, 250000, vga_clk cycles per movement tick
STEP, 2, pixels moved per tick on each axis
MAX_STEP, 6, step ceiling (used only with SPEEDUP_EN)
X_INIT, 315, serve x coordinate
Y_INIT, 235, serve y coordinate
MISS_TICKS, 60, ticks spent in MISS before returning to IDLE

Ports:
vga_clk  in  1  pixel clock, sole clock
sys_rst  in  1  synchronous active-high reset
serve  in  1  level; launches ball from IDLE
body_x  in  10  paddle left x
body_y  in  10  paddle top y
ball_x  out  10  ball left x
ball_y  out  10  ball top y
hit  out  1  one-cycle pulse on paddle contact
miss  out  1  one-cycle pulse when ball passes paddle
active  out  1  high while in MOVE

Behaviour:
- Clock/reset: one clock vga_clk; reset sys_rst is synchronous, active-high; all state updates on posedge vga_clk only.
- Reset: ball_x=X_INIT, ball_y=Y_INIT, dx=left, dy=down, step=STEP, hit=0, miss=0, active=0, state=IDLE, tick counter=0.
- Tick: counter 0..TICK_DIV-1, tick asserted for one cycle at TICK_DIV-1 then wraps to 0; free-running in all states.
- IDLE: ball held at (X_INIT,Y_INIT); serve=1 sampled on any cycle -> MOVE next cycle, dx=left, dy=down, step=STEP.
- MOVE, on tick only (no change between ticks):
  - Vertical: moving down and ball_y+step >= V_DISP-SLDE_W-BALL_W -> ball_y clamped to that limit, dy=up. Moving up and ball_y <= SLDE_W+step -> ball_y=SLDE_W, dy=down. Else ball_y +/- step.
  - Right wall: moving right and ball_x+step >= H_DISP-SLDE_W-BALL_W -> clamp, dx=left.
  - Paddle: moving left, ball_x-step <= body_x+body_w, ball_x > body_x (not yet past paddle face), and y-overlap (ball_y+BALL_W > body_y and ball_y < body_y+body_l) -> ball_x=body_x+body_w, dx=right, hit pulse.
  - Miss: moving left, ball_x <= SLDE_W+step -> ball_x=SLDE_W, miss pulse, state=MISS.
  - Corner (vertical and horizontal events same tick): both directions flip, both clamps applied.
  - Paddle check has priority over miss on the same tick.
- MISS: ball frozen; after MISS_TICKS ticks -> IDLE (ball re-centred on entry to IDLE). serve ignored in MISS.
- Arithmetic: all comparisons in 11-bit unsigned, zero-extended, so subtraction near 0 cannot wrap; outputs always within [SLDE_W, limit].
- hit/miss: registered, high exactly one vga_clk cycle; active = (state==MOVE), registered.
- Reset mid-flight: returns to the reset values on the next edge regardless of state.

Optional Feature:
SPEEDUP_EN: when defined, each hit increments step by 1 up to MAX_STEP; step returns to STEP on serve and on reset. When undefined, step is the constant STEP and MAX_STEP is unused.

Decomposition:
- Shared constants stay in config.v: H_DISP, V_DISP, SLDE_W, body_l, plus new body_w (paddle width, 10) and BALL_W default.
- State encoding (IDLE/MOVE/MISS) as localparams local to ball_ctrl.
- One sub-module: tick_gen (parameter TICK_DIV, outputs one-cycle tick); reusable by the paddle stage.

Test Plan:
Bench: H_DISP=640, V_DISP=480, SLDE_W=10, body_l=80, body_w=10, TICK_DIV=4, STEP=2.
1. Reset held 3 cycles, release, serve=0 for 100 cycles -> ball stays (315,235), active=0, hit=miss=0.
2. serve pulse; ball_y forced to 458 moving down -> next tick ball_y=460 clamped, dy=up; following tick 458.
3. body_x=55, body_y=200, ball approaching at y=230 -> ball_x clamped to 65, single-cycle hit, dx=right.
4. body_y=0, ball at y=300 moving left -> no hit; ball_x reaches 10, miss pulse once, active=0, after 60 ticks ball at (315,235).
5. Ball at top wall and right wall on same tick -> both dx and dy flip, ball_x=620, ball_y=10.
6. SPEEDUP_EN defined: 5 consecutive hits -> step 3,4,5,6,6; serve after miss -> step=2.
